// File: rtl/coo_aggregation_engine.sv
// coo_aggregation_engine
//   Streams a COO edge list (dest, src) from an external combinational-read
//   memory, fetches the FM x WM product row of each edge's source node and
//   accumulates it into an internal per-node result row. The result is
//   ADJ x (FM x WM), produced in one pass at one edge per cycle. Unsorted edge
//   lists work because a new destination row is always read back from the
//   result memory before accumulation starts (read-modify-write).
//
//   Optional feature: define COO_AGG_SATURATE_EN to make every element add
//   saturate to the signed range of DOT_PROD_WIDTH. Otherwise adds wrap.
//
// Ports
//   clk               in   rising-edge clock
//   reset             in   asynchronous active-low reset
//   start             in   single-cycle run request (ignored while busy)
//   num_edges         in   edge count for this run, sampled with start
//   coo_address       out  COO memory read address (0 outside RUN)
//   coo_in            in   [COO_BW-1:0] destination row, [2*COO_BW-1:COO_BW] source column
//   read_fm_wm_row    out  product memory row address (0 outside RUN)
//   fm_wm_row_mem_out in   product row, element j at [j*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]
//   read_row          in   result read address
//   result_row_out    out  result row at read_row, zeros when out of range
//   busy              out  high in RUN and FLUSH
//   agg_done          out  result valid (level) until the next accepted start
//   invalid_edge      out  sticky: an edge of this run was dropped
module coo_aggregation_engine #(
  parameter int NUM_OF_NODES   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int MAX_EDGES      = 64,
  parameter int COO_BW         = $clog2(NUM_OF_NODES),
  parameter int EDGE_BW        = $clog2(MAX_EDGES + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [EDGE_BW-1:0]                    num_edges,
  output logic [EDGE_BW-1:0]                    coo_address,
  input  logic [2*COO_BW-1:0]                   coo_in,
  output logic [COO_BW-1:0]                     read_fm_wm_row,
  input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_wm_row_mem_out,
  input  logic [COO_BW-1:0]                     read_row,
  output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] result_row_out,
  output logic                                  busy,
  output logic                                  agg_done,
  output logic                                  invalid_edge
);

  localparam int ROW_W = WEIGHT_COLS * DOT_PROD_WIDTH;
  localparam int W     = DOT_PROD_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [EDGE_BW-1:0] r_edge_idx;
  logic [EDGE_BW-1:0] r_num_edges;
  logic [COO_BW-1:0]  r_cur_dest;
  logic               r_acc_valid;
  logic [ROW_W-1:0]   r_acc;
  logic               r_busy;
  logic               r_agg_done;
  logic               r_invalid;
  logic [ROW_W-1:0]   r_mem [NUM_OF_NODES];

  logic [COO_BW-1:0]  w_dest;
  logic [COO_BW-1:0]  w_src;
  logic               w_edge_ok;
  logic               w_last;
  logic [ROW_W-1:0]   w_dest_row;
  logic [EDGE_BW-1:0] w_num_clamped;

  function automatic logic [W-1:0] add_elem(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
`ifdef COO_AGG_SATURATE_EN
    // Sign bits disagree after sign extension: the W-bit result overflowed.
    if (s[W] != s[W-1]) begin
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    return s[W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] add_row(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < WEIGHT_COLS; j++) begin
      r[j*W +: W] = add_elem(a[j*W +: W], b[j*W +: W]);
    end
    return r;
  endfunction

  always_comb begin
    w_dest    = coo_in[COO_BW-1:0];
    w_src     = coo_in[2*COO_BW-1:COO_BW];
    // Extra bit keeps the bound exact when NUM_OF_NODES is a power of two.
    w_edge_ok = ({1'b0, w_dest} < (COO_BW+1)'(NUM_OF_NODES)) &&
                ({1'b0, w_src}  < (COO_BW+1)'(NUM_OF_NODES));
    w_last    = (r_edge_idx == (r_num_edges - EDGE_BW'(1)));

    w_dest_row = '0;
    for (int unsigned i = 0; i < NUM_OF_NODES; i++) begin
      if (w_dest == COO_BW'(i)) w_dest_row = r_mem[i];
    end

    result_row_out = '0;
    for (int unsigned i = 0; i < NUM_OF_NODES; i++) begin
      if (read_row == COO_BW'(i)) result_row_out = r_mem[i];
    end

    w_num_clamped = (num_edges > EDGE_BW'(MAX_EDGES)) ? EDGE_BW'(MAX_EDGES) : num_edges;

    coo_address    = (r_state == S_RUN) ? r_edge_idx : '0;
    read_fm_wm_row = (r_state == S_RUN) ? w_src : '0;
  end

  assign busy         = r_busy;
  assign agg_done     = r_agg_done;
  assign invalid_edge = r_invalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_edge_idx  <= '0;
      r_num_edges <= '0;
      r_cur_dest  <= '0;
      r_acc_valid <= 1'b0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_agg_done  <= 1'b0;
      r_invalid   <= 1'b0;
      for (int unsigned i = 0; i < NUM_OF_NODES; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int unsigned i = 0; i < NUM_OF_NODES; i++) r_mem[i] <= '0;
            r_invalid   <= 1'b0;
            r_edge_idx  <= '0;
            r_acc_valid <= 1'b0;
            r_num_edges <= w_num_clamped;
            r_agg_done  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= (w_num_clamped == '0) ? S_FLUSH : S_RUN;
          end
        end
        S_RUN: begin
          if (!w_edge_ok) begin
            r_invalid <= 1'b1;
          end else if (r_acc_valid && (w_dest == r_cur_dest)) begin
            r_acc <= add_row(r_acc, fm_wm_row_mem_out);
          end else begin
            // Retire the open row and open the new one from its stored value;
            // the two rows differ, so the write and the read never collide.
            if (r_acc_valid) begin
              for (int unsigned i = 0; i < NUM_OF_NODES; i++) begin
                if (r_cur_dest == COO_BW'(i)) r_mem[i] <= r_acc;
              end
            end
            r_acc       <= add_row(w_dest_row, fm_wm_row_mem_out);
            r_cur_dest  <= w_dest;
            r_acc_valid <= 1'b1;
          end
          r_edge_idx <= r_edge_idx + EDGE_BW'(1);
          if (w_last) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_acc_valid) begin
            for (int unsigned i = 0; i < NUM_OF_NODES; i++) begin
              if (r_cur_dest == COO_BW'(i)) r_mem[i] <= r_acc;
            end
          end
          r_acc_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_agg_done  <= 1'b1;
          r_state     <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coo_aggregation_engine.sv
module tb_coo_aggregation_engine;

  localparam int CB = 3;
  localparam int EB = 7;
  localparam int RW = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [EB-1:0] num_edges;
  logic [EB-1:0] coo_address;
  logic [2*CB-1:0] coo_in;
  logic [CB-1:0] read_fm_wm_row;
  logic [RW-1:0] fm_wm_row_mem_out;
  logic [CB-1:0] read_row;
  logic [RW-1:0] result_row_out;
  logic          busy;
  logic          agg_done;
  logic          invalid_edge;

  logic [CB-1:0] e_d [128];
  logic [CB-1:0] e_s [128];
  logic [RW-1:0] prod [8];

  typedef struct {
    logic [CB-1:0] row;
    logic [RW-1:0] val;
  } exp_t;
  exp_t sb[$];
  logic exp_inv;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign coo_in            = {e_s[coo_address], e_d[coo_address]};
  assign fm_wm_row_mem_out = prod[read_fm_wm_row];

  coo_aggregation_engine #(
    .NUM_OF_NODES(6), .WEIGHT_COLS(3), .DOT_PROD_WIDTH(16), .MAX_EDGES(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_edges(num_edges),
    .coo_address(coo_address), .coo_in(coo_in), .read_fm_wm_row(read_fm_wm_row),
    .fm_wm_row_mem_out(fm_wm_row_mem_out), .read_row(read_row),
    .result_row_out(result_row_out), .busy(busy), .agg_done(agg_done),
    .invalid_edge(invalid_edge)
  );

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] s;
    s = 32'($signed(a)) + 32'($signed(b));
`ifdef COO_AGG_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  // Reference model: pushes the expected contents of rows 0..7 to the scoreboard.
  task automatic model(input int n);
    logic [RW-1:0] m [8];
    int nn;
    nn = (n > 64) ? 64 : n;
    exp_inv = 1'b0;
    for (int r = 0; r < 8; r++) m[r] = '0;
    for (int i = 0; i < nn; i++) begin
      if (e_d[i] < 6 && e_s[i] < 6) begin
        for (int j = 0; j < 3; j++)
          m[e_d[i]][j*16 +: 16] = m_add(m[e_d[i]][j*16 +: 16], prod[e_s[i]][j*16 +: 16]);
      end else begin
        exp_inv = 1'b1;
      end
    end
    for (int r = 0; r < 8; r++) sb.push_back('{row: CB'(r), val: m[r]});
  endtask

  // Pulse start, then count edges until agg_done (bounded).
  task automatic launch(input int n, output int lat, output logic b0, output logic d0);
    @(negedge clk);
    start = 1'b1;
    num_edges = EB'(n);
    @(posedge clk);
    #1 start = 1'b0;
    b0 = busy;
    d0 = agg_done;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (agg_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic clear_edges();
    for (int i = 0; i < 128; i++) begin
      e_d[i] = '0;
      e_s[i] = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({coo_address, read_fm_wm_row, busy, agg_done, invalid_edge} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%0d row=%0d busy=%b done=%b inv=%b required all 0",
               coo_address, read_fm_wm_row, busy, agg_done, invalid_edge);
    end
    for (int r = 0; r < 8; r++) begin
      read_row = CB'(r);
      #1;
      checks++;
      if (result_row_out !== '0) begin
        errors++;
        $display("FAIL reset_row%0d got %h required 0", r, result_row_out);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_sorted();
    int lat; logic b0, d0; exp_t e;
    clear_edges();
    e_d[0] = 0; e_s[0] = 1;
    e_d[1] = 0; e_s[1] = 2;
    e_d[2] = 1; e_s[2] = 0;
    model(3);
    launch(3, lat, b0, d0);
    checks++;
    if (lat !== 4 || b0 !== 1'b1 || d0 !== 1'b0) begin
      errors++;
      $display("FAIL sorted_timing got lat=%0d busy=%b done=%b required lat=4 busy=1 done=0", lat, b0, d0);
    end
    checks++;
    if (busy !== 1'b0 || invalid_edge !== exp_inv) begin
      errors++;
      $display("FAIL sorted_flags got busy=%b inv=%b required busy=0 inv=%b", busy, invalid_edge, exp_inv);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_row = e.row;
      #1;
      checks++;
      if (result_row_out !== e.val) begin
        errors++;
        $display("FAIL sorted_row%0d got %h required %h", e.row, result_row_out, e.val);
      end
    end
    read_row = 0;
    #1;
    checks++;
    if (result_row_out !== {16'd15, 16'd13, 16'd11}) begin
      errors++;
      $display("FAIL sorted_row0_const got %h required 000f000d000b", result_row_out);
    end
  endtask

  task automatic test_unsorted();
    int lat; logic b0, d0; exp_t e;
    clear_edges();
    e_d[0] = 0; e_s[0] = 1;
    e_d[1] = 1; e_s[1] = 0;
    e_d[2] = 0; e_s[2] = 2;
    model(3);
    launch(3, lat, b0, d0);
    checks++;
    if (lat !== 4 || invalid_edge !== exp_inv) begin
      errors++;
      $display("FAIL unsorted_timing got lat=%0d inv=%b required lat=4 inv=%b", lat, invalid_edge, exp_inv);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_row = e.row;
      #1;
      checks++;
      if (result_row_out !== e.val) begin
        errors++;
        $display("FAIL unsorted_row%0d got %h required %h", e.row, result_row_out, e.val);
      end
    end
  endtask

  task automatic test_invalid_edge();
    int lat; logic b0, d0; exp_t e;
    clear_edges();
    e_d[0] = 0; e_s[0] = 1;
    e_d[1] = 7; e_s[1] = 0;
    e_d[2] = 2; e_s[2] = 2;
    model(3);
    launch(3, lat, b0, d0);
    checks++;
    if (lat !== 4 || invalid_edge !== 1'b1 || exp_inv !== 1'b1) begin
      errors++;
      $display("FAIL invalid_flag got lat=%0d inv=%b required lat=4 inv=1", lat, invalid_edge);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_row = e.row;
      #1;
      checks++;
      if (result_row_out !== e.val) begin
        errors++;
        $display("FAIL invalid_row%0d got %h required %h", e.row, result_row_out, e.val);
      end
    end
  endtask

  task automatic test_zero_edges();
    int lat; logic b0, d0; exp_t e;
    model(0);
    launch(0, lat, b0, d0);
    checks++;
    if (lat !== 1 || b0 !== 1'b1 || invalid_edge !== 1'b0) begin
      errors++;
      $display("FAIL zero_timing got lat=%0d busy=%b inv=%b required lat=1 busy=1 inv=0", lat, b0, invalid_edge);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_row = e.row;
      #1;
      checks++;
      if (result_row_out !== e.val) begin
        errors++;
        $display("FAIL zero_row%0d got %h required %h", e.row, result_row_out, e.val);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat; exp_t e;
    clear_edges();
    for (int i = 0; i < 10; i++) begin
      e_d[i] = CB'($urandom_range(0, 5));
      e_s[i] = CB'($urandom_range(0, 5));
    end
    model(10);
    @(negedge clk);
    start = 1'b1;
    num_edges = 10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    num_edges = 2;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 5; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (agg_done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL busy_start_timing got lat=%0d required 11", lat);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_row = e.row;
      #1;
      checks++;
      if (result_row_out !== e.val) begin
        errors++;
        $display("FAIL busy_start_row%0d got %h required %h", e.row, result_row_out, e.val);
      end
    end
  endtask

  task automatic test_saturate();
    int lat; logic b0, d0; exp_t e; logic [15:0] want;
`ifdef COO_AGG_SATURATE_EN
    want = 16'h7FFF;
`else
    want = 16'hE000;
`endif
    clear_edges();
    prod[3] = {16'h7000, 16'h7000, 16'h7000};
    e_d[0] = 0; e_s[0] = 3;
    e_d[1] = 0; e_s[1] = 3;
    model(2);
    launch(2, lat, b0, d0);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL sat_timing got lat=%0d required 3", lat);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_row = e.row;
      #1;
      checks++;
      if (result_row_out !== e.val) begin
        errors++;
        $display("FAIL sat_row%0d got %h required %h", e.row, result_row_out, e.val);
      end
    end
    read_row = 0;
    #1;
    checks++;
    if (result_row_out !== {want, want, want}) begin
      errors++;
      $display("FAIL sat_const got %h required %h%h%h", result_row_out, want, want, want);
    end
  endtask

  task automatic test_random_clamp();
    int lat; logic b0, d0; exp_t e;
    for (int r = 0; r < 8; r++) prod[r] = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    for (int i = 0; i < 128; i++) begin
      e_d[i] = CB'($urandom_range(0, 6));
      e_s[i] = CB'($urandom_range(0, 6));
    end
    model(100);
    launch(100, lat, b0, d0);
    checks++;
    if (lat !== 65 || invalid_edge !== exp_inv) begin
      errors++;
      $display("FAIL clamp_timing got lat=%0d inv=%b required lat=65 inv=%b", lat, invalid_edge, exp_inv);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_row = e.row;
      #1;
      checks++;
      if (result_row_out !== e.val) begin
        errors++;
        $display("FAIL clamp_row%0d got %h required %h", e.row, result_row_out, e.val);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic b0, d0; exp_t e;
    clear_edges();
    for (int i = 0; i < 12; i++) begin
      e_d[i] = CB'($urandom_range(0, 5));
      e_s[i] = CB'($urandom_range(0, 7));
    end
    @(negedge clk);
    start = 1'b1;
    num_edges = 12;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({coo_address, read_fm_wm_row, busy, agg_done, invalid_edge} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got addr=%0d row=%0d busy=%b done=%b inv=%b required all 0",
               coo_address, read_fm_wm_row, busy, agg_done, invalid_edge);
    end
    for (int r = 0; r < 6; r++) begin
      read_row = CB'(r);
      #1;
      checks++;
      if (result_row_out !== '0) begin
        errors++;
        $display("FAIL midreset_row%0d got %h required 0", r, result_row_out);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model(12);
    launch(12, lat, b0, d0);
    checks++;
    if (lat !== 13 || invalid_edge !== exp_inv) begin
      errors++;
      $display("FAIL rerun_timing got lat=%0d inv=%b required lat=13 inv=%b", lat, invalid_edge, exp_inv);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_row = e.row;
      #1;
      checks++;
      if (result_row_out !== e.val) begin
        errors++;
        $display("FAIL rerun_row%0d got %h required %h", e.row, result_row_out, e.val);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    num_edges = '0;
    read_row = '0;
    clear_edges();
    prod[0] = {16'd3, 16'd2, 16'd1};
    prod[1] = {16'd6, 16'd5, 16'd4};
    prod[2] = {16'd9, 16'd8, 16'd7};
    for (int r = 3; r < 8; r++) prod[r] = {16'd100, 16'd200, 16'd300};
    test_reset();
    test_sorted();
    test_unsorted();
    test_invalid_edge();
    test_zero_edges();
    test_start_while_busy();
    test_saturate();
    test_random_clamp();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
